// File: rtl/mem_arbiter_pkg.sv
// Shared encodings for the two-port SRAM arbiter.
// Covers the FSM states, data-port commands, grant identifiers and the WE pulse counter width.
package mem_arbiter_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_RD       = 3'd1,
    ST_WR_SETUP = 3'd2,
    ST_WR_PULSE = 3'd3,
    ST_WR_HOLD  = 3'd4
  } arbState_e;

  typedef enum logic [1:0] {
    CTRL_IDLE = 2'b00,
    CTRL_RD   = 2'b01,
    CTRL_WR   = 2'b10,
    CTRL_RSVD = 2'b11
  } aCtrl_e;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_e;

  localparam int CNT_W = 4;

  // Only read and write are real requests; the reserved code behaves like idle.
  function automatic logic isAccess(input logic [1:0] ctrl);
    return (ctrl == CTRL_RD) || (ctrl == CTRL_WR);
  endfunction

endpackage

// File: rtl/mem_arbiter_we_pulse_timer.sv
// Down-counter that times the SRAM write-enable pulse.
// It loads a preset, decrements to zero and then holds there.
module we_pulse_timer
  import mem_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] loadVal,
  input  logic             dec,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (load) begin
      count <= loadVal;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a CPU data port (A) and an instruction-fetch port (B) onto one asynchronous SRAM.
// Every SRAM strobe and the pad drive enable come straight from flops.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 16,
  parameter int WE_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        a_ctrl,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_done,
  input  logic              b_req,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_done,
  output logic              busy,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_dout,
  input  logic [DATA_W-1:0] ram_din,
  output logic              ram_drive,
  output logic              ram_ce_n,
  output logic              ram_oe_n,
  output logic              ram_we_n,
  output arbState_e         dbgState
);

  localparam logic [CNT_W-1:0] WE_LOAD = CNT_W'(WE_CYCLES - 1);

  // Handshake: a request (a_ctrl read/write, or b_req) is taken only on an edge
  // where the FSM is IDLE and that port wins arbitration; the request may then be
  // dropped. Completion is a single-cycle a_done/b_done; rdata stays valid until
  // the next completion on the same port.

  arbState_e state, stateNext;
  grant_e    lastGrant, curPort;
  logic      aReq;
  logic      grantA, grantB;
  logic      timerLoad, timerDec, timerZero;

  assign aReq = isAccess(a_ctrl);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    grantA    = 1'b0;
    grantB    = 1'b0;
    timerLoad = 1'b0;
    timerDec  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        // B takes the slot when A is absent or A was served last, so neither port starves.
        if (b_req && (!aReq || (lastGrant == GRANT_A))) begin
          grantB    = 1'b1;
          stateNext = ST_RD;
        end else if (aReq) begin
          grantA    = 1'b1;
          stateNext = (a_ctrl == CTRL_WR) ? ST_WR_SETUP : ST_RD;
        end
      end
      ST_RD:       stateNext = ST_IDLE;
      ST_WR_SETUP: begin
        timerLoad = 1'b1;
        stateNext = ST_WR_PULSE;
      end
      ST_WR_PULSE: begin
        if (timerZero) begin
          stateNext = ST_WR_HOLD;
        end else begin
          timerDec = 1'b1;
        end
      end
      ST_WR_HOLD:  stateNext = ST_IDLE;
      default:     stateNext = ST_IDLE;
    endcase
  end

  we_pulse_timer u_weTimer (
    .clk     (clk),
    .rst     (rst),
    .load    (timerLoad),
    .loadVal (WE_LOAD),
    .dec     (timerDec),
    .zero    (timerZero)
  );

  // Strobes are registered from the next state so they line up with the state they describe.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_ce_n  <= 1'b1;
      ram_oe_n  <= 1'b1;
      ram_we_n  <= 1'b1;
      ram_drive <= 1'b0;
    end else begin
      ram_ce_n  <= (stateNext == ST_IDLE);
      ram_oe_n  <= (stateNext != ST_RD);
      ram_we_n  <= (stateNext != ST_WR_PULSE);
      ram_drive <= (stateNext inside {ST_WR_SETUP, ST_WR_PULSE, ST_WR_HOLD});
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ram_addr  <= '0;
      ram_dout  <= '0;
      lastGrant <= GRANT_B;
      curPort   <= GRANT_A;
    end else if (grantA) begin
      ram_addr  <= a_addr;
      lastGrant <= GRANT_A;
      curPort   <= GRANT_A;
      if (a_ctrl == CTRL_WR) begin
        ram_dout <= a_wdata;
      end
    end else if (grantB) begin
      ram_addr  <= b_addr;
      lastGrant <= GRANT_B;
      curPort   <= GRANT_B;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      a_rdata <= '0;
      b_rdata <= '0;
      a_done  <= 1'b0;
      b_done  <= 1'b0;
    end else begin
      a_done <= 1'b0;
      b_done <= 1'b0;
      if (state == ST_RD) begin
        if (curPort == GRANT_A) begin
          a_rdata <= ram_din;
          a_done  <= 1'b1;
        end else begin
          b_rdata <= ram_din;
          b_done  <= 1'b1;
        end
      end
      if (state == ST_WR_HOLD) begin
        a_done <= 1'b1;
      end
    end
  end

  assign busy     = (state != ST_IDLE);
  assign dbgState = state;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural SRAM, per-port expected queues,
// strobe/timing monitors, directed scenarios plus a random access mix.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  localparam int AW  = 16;
  localparam int DW  = 16;
  localparam int WEC = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    a_ctrl = 2'b00;
  logic [AW-1:0] a_addr = '0;
  logic [DW-1:0] a_wdata = '0;
  logic [DW-1:0] a_rdata;
  logic          a_done;
  logic          b_req = 1'b0;
  logic [AW-1:0] b_addr = '0;
  logic [DW-1:0] b_rdata;
  logic          b_done;
  logic          busy;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_dout;
  logic [DW-1:0] ram_din;
  logic          ram_drive, ram_ce_n, ram_oe_n, ram_we_n;
  arbState_e     dbgState;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WE_CYCLES(WEC)) dut (
    .clk(clk), .rst(rst),
    .a_ctrl(a_ctrl), .a_addr(a_addr), .a_wdata(a_wdata), .a_rdata(a_rdata), .a_done(a_done),
    .b_req(b_req), .b_addr(b_addr), .b_rdata(b_rdata), .b_done(b_done),
    .busy(busy), .ram_addr(ram_addr), .ram_dout(ram_dout), .ram_din(ram_din),
    .ram_drive(ram_drive), .ram_ce_n(ram_ce_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n),
    .dbgState(dbgState)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- SRAM model ----------------
  logic [DW-1:0] sram [0:65535];
  logic [DW-1:0] refMem [0:15];

  assign ram_din = (!ram_ce_n && !ram_oe_n) ? sram[ram_addr] : 16'hDEAD;

  always @(posedge clk) begin
    if (!ram_ce_n && !ram_we_n && ram_drive) sram[ram_addr] = ram_dout;
  end

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [DW-1:0] expA_q[$];
  logic [DW-1:0] expB_q[$];
  logic [DW-1:0] aModel = '0;
  grant_e        lastModel = GRANT_B;
  int aDoneCnt = 0, bDoneCnt = 0;
  int doneLog[$];
  int weRun = 0, lastWeLen = 0, oeRun = 0, lastOeLen = 0, protoErr = 0;
  logic          prevDrive = 1'b0;
  logic [DW-1:0] prevDout = '0;

  task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (a_done) begin
      aDoneCnt++;
      doneLog.push_back(0);
      if (expA_q.size() == 0) checkEq("a_done_spurious", 1, 0);
      else checkEq("a_rdata", a_rdata, expA_q.pop_front());
    end
    if (b_done) begin
      bDoneCnt++;
      doneLog.push_back(1);
      if (expB_q.size() == 0) checkEq("b_done_spurious", 1, 0);
      else checkEq("b_rdata", b_rdata, expB_q.pop_front());
    end
    if (!ram_we_n) weRun++;
    else if (weRun != 0) begin lastWeLen = weRun; weRun = 0; end
    if (!ram_oe_n) oeRun++;
    else if (oeRun != 0) begin lastOeLen = oeRun; oeRun = 0; end
    if (!ram_we_n && (!ram_drive || !ram_oe_n || ram_ce_n)) protoErr++;
    if (!ram_oe_n && ram_drive) protoErr++;
    if (ram_drive && prevDrive && (ram_dout !== prevDout)) protoErr++;
    prevDrive = ram_drive;
    prevDout  = ram_dout;
  end

  // ---------------- driver tasks ----------------
  task automatic waitIdle();
    bit ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    if (!ok) checkEq("idle_timeout", 0, 1);
  endtask

  // One single-port access; lat counts rising edges from the grant edge to done visible.
  task automatic runAccess(input bit isB, input logic [1:0] ctrl, input logic [AW-1:0] addr,
                           input logic [DW-1:0] wdata, input logic [DW-1:0] exp, output int lat);
    waitIdle();
    if (isB) begin
      b_req = 1'b1; b_addr = addr;
      expB_q.push_back(exp);
      lastModel = GRANT_B;
    end else begin
      a_ctrl = ctrl; a_addr = addr; a_wdata = wdata;
      if (ctrl == CTRL_RD) aModel = exp;
      expA_q.push_back(aModel);
      lastModel = GRANT_A;
    end
    lat = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin a_ctrl = CTRL_IDLE; b_req = 1'b0; end
      if ((isB && b_done) || (!isB && a_done)) break;
    end
    @(negedge clk);
  endtask

  // Both ports request on the same edge; the expected winner is dropped after its grant.
  task automatic tieAccess(input logic [AW-1:0] aAd, input logic [AW-1:0] bAd,
                           input logic [DW-1:0] aExp, input logic [DW-1:0] bExp);
    bit bFirst;
    int logStart, first, second;
    waitIdle();
    bFirst = (lastModel == GRANT_A);
    a_ctrl = CTRL_RD; a_addr = aAd;
    b_req = 1'b1; b_addr = bAd;
    aModel = aExp;
    expA_q.push_back(aExp);
    expB_q.push_back(bExp);
    logStart = doneLog.size();
    @(negedge clk);
    if (bFirst) b_req = 1'b0; else a_ctrl = CTRL_IDLE;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!busy) break;
    end
    @(negedge clk);
    a_ctrl = CTRL_IDLE; b_req = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (doneLog.size() >= logStart + 2) break;
    end
    first  = (doneLog.size() > logStart)     ? doneLog[logStart]     : 9;
    second = (doneLog.size() > logStart + 1) ? doneLog[logStart + 1] : 9;
    checkEq("tie_first",  first,  bFirst ? 1 : 0);
    checkEq("tie_second", second, bFirst ? 0 : 1);
    lastModel = bFirst ? GRANT_A : GRANT_B;
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int lat, cnt, errs, kind, idx;
    logic [DW-1:0] d;
    logic [AW-1:0] ad;

    for (int i = 0; i < 16; i++) begin
      refMem[i] = 16'($urandom_range(0, 65535));
      sram[16'h0100 + i] = refMem[i];
    end
    sram[16'h0010] = 16'h4A21;
    sram[16'h0011] = 16'h5678;
    sram[16'h8000] = 16'h1234;
    sram[16'h9000] = 16'h1111;

    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkEq("rst_ce_n", ram_ce_n, 1);
    checkEq("rst_oe_n", ram_oe_n, 1);
    checkEq("rst_we_n", ram_we_n, 1);
    checkEq("rst_drive", ram_drive, 0);
    checkEq("rst_addr", ram_addr, 0);
    checkEq("rst_dout", ram_dout, 0);
    checkEq("rst_a_rdata", a_rdata, 0);
    checkEq("rst_b_rdata", b_rdata, 0);
    checkEq("rst_dones", {a_done, b_done}, 0);
    checkEq("rst_busy", busy, 0);
    rst = 1'b1;

    // Tie straight out of reset: A first, then B.
    tieAccess(16'h8000, 16'h0011, 16'h1234, 16'h5678);

    runAccess(1'b1, CTRL_IDLE, 16'h0010, '0, 16'h4A21, lat);
    checkEq("b_fetch_latency", lat, 2);
    checkEq("b_oe_cycles", lastOeLen, 1);

    cnt = aDoneCnt;
    runAccess(1'b0, CTRL_WR, 16'h8000, 16'hBEEF, '0, lat);
    checkEq("a_write_latency", lat, 3 + WEC);
    checkEq("a_write_we_cycles", lastWeLen, WEC);
    checkEq("a_write_sram", sram[16'h8000], 16'hBEEF);
    checkEq("a_write_done_once", aDoneCnt - cnt, 1);

    // Address changes while the read is in flight.
    waitIdle();
    a_ctrl = CTRL_RD; a_addr = 16'h8000;
    aModel = 16'hBEEF; expA_q.push_back(16'hBEEF); lastModel = GRANT_A;
    @(negedge clk);
    a_addr = 16'h9000; a_ctrl = CTRL_IDLE;
    checkEq("ram_addr_latched", ram_addr, 16'h8000);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_done) break;
    end

    // A was served last, so this tie goes to B first.
    tieAccess(16'h0010, 16'h0011, 16'h4A21, 16'h5678);

    waitIdle();
    cnt = aDoneCnt + bDoneCnt;
    errs = 0;
    a_ctrl = CTRL_RSVD; a_addr = 16'h0100;
    repeat (10) begin
      @(negedge clk);
      if (ram_ce_n !== 1'b1 || ram_we_n !== 1'b1 || ram_oe_n !== 1'b1 || busy !== 1'b0) errs++;
    end
    a_ctrl = CTRL_IDLE;
    checkEq("rsvd_no_access", errs, 0);
    checkEq("rsvd_no_done", aDoneCnt + bDoneCnt, cnt);

    // Request withdrawn between edges never reaches the arbiter.
    waitIdle();
    cnt = aDoneCnt + bDoneCnt;
    errs = 0;
    #1 a_ctrl = CTRL_RD; a_addr = 16'h0101;
    #2 a_ctrl = CTRL_IDLE;
    repeat (4) begin
      @(negedge clk);
      if (ram_ce_n !== 1'b1 || busy !== 1'b0) errs++;
    end
    checkEq("withdrawn_no_access", errs, 0);
    checkEq("withdrawn_no_done", aDoneCnt + bDoneCnt, cnt);

    for (int n = 0; n < 24; n++) begin
      kind = $urandom_range(0, 2);
      idx  = $urandom_range(0, 15);
      ad   = 16'h0100 + 16'(idx);
      case (kind)
        0: begin
          runAccess(1'b0, CTRL_RD, ad, '0, refMem[idx], lat);
          checkEq("rand_a_read_latency", lat, 2);
        end
        1: begin
          d = 16'($urandom_range(0, 65535));
          refMem[idx] = d;
          runAccess(1'b0, CTRL_WR, ad, d, '0, lat);
          checkEq("rand_a_write_latency", lat, 3 + WEC);
        end
        default: begin
          runAccess(1'b1, CTRL_IDLE, ad, '0, refMem[idx], lat);
          checkEq("rand_b_read_latency", lat, 2);
        end
      endcase
    end

    // Reset in the middle of the write pulse.
    waitIdle();
    a_ctrl = CTRL_WR; a_addr = 16'h7000; a_wdata = 16'h5555;
    expA_q.push_back(aModel);
    @(negedge clk);
    a_ctrl = CTRL_IDLE;
    @(negedge clk);
    checkEq("we_low_before_reset", ram_we_n, 0);
    cnt = aDoneCnt;
    #2 rst = 1'b0;
    #1;
    checkEq("async_we_n", ram_we_n, 1);
    checkEq("async_drive", ram_drive, 0);
    checkEq("async_ce_oe", {ram_ce_n, ram_oe_n}, 2'b11);
    checkEq("async_busy", busy, 0);
    checkEq("async_addr_dout", {ram_addr, ram_dout}, 0);
    checkEq("async_rdata", {a_rdata, b_rdata}, 0);
    expA_q.delete();
    expB_q.delete();
    aModel = '0;
    lastModel = GRANT_B;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checkEq("abandoned_write_no_done", aDoneCnt, cnt);
    checkEq("post_reset_idle", {busy, ram_ce_n, ram_we_n}, 3'b011);

    runAccess(1'b1, CTRL_IDLE, 16'h0010, '0, 16'h4A21, lat);
    checkEq("recovery_latency", lat, 2);

    checkEq("strobe_protocol_errors", protoErr, 0);
    checkEq("expA_q_empty", expA_q.size(), 0);
    checkEq("expB_q_empty", expB_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 16, width of CPU and SRAM address.
REQ-002 Parameter DATA_W, 16, width of data words.
REQ-003 Parameter WE_CYCLES, 1, cycles we_n is held low per write (legal range 1..15).
REQ-004 clk  in  1  single clock; all logic on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-low.
REQ-006 a_ctrl  in  2  data-port command: 00 idle, 01 read, 10 write, 11 treated as idle.
REQ-007 a_addr  in  ADDR_W  data-port address.
REQ-008 a_wdata  in  DATA_W  data-port write data.
REQ-009 a_rdata  out  DATA_W  data-port read result.
REQ-010 a_done  out  1  one-cycle pulse marking data-port completion.
REQ-011 b_req  in  1  instruction-fetch request.
REQ-012 b_addr  in  ADDR_W  fetch address (PC).
REQ-013 b_rdata  out  DATA_W  fetched instruction word.
REQ-014 b_done  out  1  one-cycle pulse marking fetch completion.
REQ-015 busy  out  1  high while the FSM is not IDLE; drives the CPU pipeline stall.
REQ-016 ram_addr  out  ADDR_W  SRAM address.
REQ-017 ram_dout  out  DATA_W  SRAM write data.
REQ-018 ram_din  in  DATA_W  SRAM read data.
REQ-019 ram_drive  out  1  tristate enable for ram_dout at the pad.
REQ-020 ram_ce_n, ram_oe_n, ram_we_n  out  1 each  active-low SRAM strobes.

Function
REQ-021 The FSM SHALL have the states IDLE, RD, WR_SETUP, WR_PULSE and WR_HOLD.
REQ-022 In IDLE, a_ctrl of 01 or 10 and b_req are sampled each edge; with no request, the FSM stays in IDLE.
REQ-023 Arbitration: A wins unless last_grant=A and b_req=1; B then wins, so B is never starved.
REQ-024 On grant, address, data and command SHALL be latched; later input changes SHALL NOT affect the access in flight.
REQ-025 A read (A read or B fetch) SHALL go IDLE->RD for one cycle with ce_n=0, oe_n=0 and ram_addr=latched address.
REQ-026 At the edge leaving RD, ram_din is registered into a_rdata or b_rdata and the matching done pulses high for the following cycle.
REQ-027 Read latency: grant edge to done-high edge is exactly 2 edges.
REQ-028 A write SHALL sequence WR_SETUP (1 cycle, ce_n=0, we_n=1), then WR_PULSE (WE_CYCLES cycles, we_n=0), then WR_HOLD (1 cycle, we_n=1).
REQ-029 ram_drive=1 and ram_dout is held stable from WR_SETUP through WR_HOLD; oe_n=1 throughout the write.
REQ-030 WR_PULSE duration SHALL be counted by a 4-bit down-counter loaded with WE_CYCLES-1.
REQ-031 a_done SHALL pulse in the cycle after WR_HOLD.
REQ-032 The FSM SHALL return to IDLE after every access; back-to-back accesses therefore incur one IDLE cycle each.
REQ-033 The rdata registers SHALL hold their value until the next completion on the same port.
REQ-034 All SRAM strobes and ram_drive SHALL be driven directly from flops, glitch-free.
REQ-035 A request withdrawn before grant SHALL produce no access and no done.
REQ-036 a_ctrl=11 SHALL produce no access.

Reset
REQ-037 While rst=0: state=IDLE, last_grant=B, ram_ce_n=ram_oe_n=ram_we_n=1, ram_drive=0, ram_addr=0, ram_dout=0, a_rdata=b_rdata=0, a_done=b_done=0, busy=0.
REQ-038 Reset asserted mid-write SHALL force we_n=1 and ram_drive=0 immediately, without waiting for clk, and the write is abandoned.
REQ-039 After rst rises, the first grant SHALL occur no earlier than the first rising edge.

Structure
REQ-040 A shared package SHALL hold the state encoding, the a_ctrl encodings (IDLE/RD/WR) and the grant identifiers A/B.
REQ-041 The WE pulse counter SHALL be the single sub-module we_pulse_timer (load, decrement, zero flag).
REQ-042 The pad tristate SHALL be instantiated outside this module.

Verification
REQ-043 B fetch only: b_req=1, b_addr=0x0010, SRAM[0x0010]=0x4A21 -> oe_n low 1 cycle, b_done at edge+2, b_rdata=0x4A21.
REQ-044 A write: a_ctrl=10, a_addr=0x8000, a_wdata=0xBEEF, WE_CYCLES=3 -> we_n low exactly 3 cycles, data stable setup through hold, a_done once, SRAM[0x8000]=0xBEEF.
REQ-045 Simultaneous A read 0x8000 and B fetch 0x0011 from reset -> A served first, then B; next tie -> B first after an A grant.
REQ-046 Inputs changed mid-access: a_addr changed from 0x8000 to 0x9000 during RD -> access still uses 0x8000.
REQ-047 Reset during WR_PULSE -> we_n=1 and ram_drive=0 before the next clk edge, all outputs at reset values, no done pulse.
REQ-048 a_ctrl=11 held 10 cycles -> strobes stay high, busy=0, no done pulse.
